// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   fetchState_e  : instruction fetch sequencer states (BOOT/FETCH/DRAIN)
//   JMP_*         : decode-stage jump type encodings carried on JumpIn
//   NOP_INSTR_WORD: default bubble word for the IF/ID register
//   ifIdPayload_t : contents of the IF/ID pipeline register
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifIdPayload_t;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry holding register for an instruction word that returned from
// memory while decode was stalled.
// Ports:
//   Clk, Reset           : clock, asynchronous active-low reset
//   load                 : capture loadInstr/loadPc4 and mark full
//   drain                : entry consumed, mark empty
//   clear                : discard entry (redirect), highest priority
//   loadInstr, loadPc4   : word and its PC+4 to capture
//   full                 : entry holds a valid word
//   holdInstr, holdPc4   : stored word and its PC+4
module fetch_hold_buffer
    import mips_pipe_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] loadInstr,
    input  logic [31:0] loadPc4,
    output logic        full,
    output logic [31:0] holdInstr,
    output logic [31:0] holdPc4
);

    // Clear beats load so a word returning in the same cycle as a redirect
    // can never survive into the new instruction stream.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            full      <= 1'b0;
            holdInstr <= NOP_INSTR_WORD;
            holdPc4   <= 32'h0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            holdInstr <= loadInstr;
            holdPc4   <= loadPc4;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline. Owns the PC, fetches words over a
// req/valid handshake, selects the next PC (sequential, decode jumps, EX
// branch) and drives the IF/ID register. No delay slots: wrong-path words
// are squashed.
// Ports:
//   Clk, Reset                      : clock, asynchronous active-low reset
//   StallIn                         : hazard unit stall of IF/ID and PC
//   BranchTakenIn, BranchTargetIn   : EX-stage taken branch and target
//   JumpIn, JumpTargetIn, JumpRegTargetIn : decode-stage jump type/targets
//   ImemReqOut, ImemAddrOut         : fetch request and word address
//   ImemDataIn, ImemValidIn         : fetch response
//   InstructionOut, PCValueOut, ValidOut : IF/ID register
// Optional build macro FETCH_STATS_EN adds FetchCountOut / SquashCountOut,
// saturating counters of accepted and dropped responses.
module instruction_fetch_unit
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pipe_pkg::NOP_INSTR_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        StallIn,
    input  logic        BranchTakenIn,
    input  logic [31:0] BranchTargetIn,
    input  logic [1:0]  JumpIn,
    input  logic [31:0] JumpTargetIn,
    input  logic [31:0] JumpRegTargetIn,
    output logic        ImemReqOut,
    output logic [31:0] ImemAddrOut,
    input  logic [31:0] ImemDataIn,
    input  logic        ImemValidIn,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCValueOut,
    output logic        ValidOut
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] FetchCountOut,
    output logic [31:0] SquashCountOut
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
    localparam ifIdPayload_t BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    fetchState_e  state, nextState;
    ifIdPayload_t ifId, nextIfId;
    logic [31:0]  pc, nextPc, pcPlus4;
    logic [31:0]  rawTarget, redirectTarget;
    logic [1:0]   jumpKind;
    logic         jumpActive, redirect;
    logic         reqActive, respAccept, respDrop;
    logic         holdLoad, holdDrain, holdClear, holdFull;
    logic [31:0]  holdInstr, holdPc4;

    assign pcPlus4 = pc + 32'd4;

    // Reserved jump encoding folds to "no jump"; a stalled decode stage
    // cannot redirect because its jump is not yet committed.
    always_comb begin
        jumpKind = JumpIn;
        if ((JumpIn != JMP_J) && (JumpIn != JMP_JR)) begin
            jumpKind = JMP_NONE;
        end
    end

    assign jumpActive = !StallIn && (jumpKind != JMP_NONE);
    assign redirect   = BranchTakenIn | jumpActive;

    // Branch is older than the decode-stage jump, so it wins.
    always_comb begin
        rawTarget = JumpTargetIn;
        if (BranchTakenIn) begin
            rawTarget = BranchTargetIn;
        end else if (jumpKind == JMP_JR) begin
            rawTarget = JumpRegTargetIn;
        end
    end

    assign redirectTarget = rawTarget & 32'hFFFF_FFFC;

    // A request is outstanding whenever FETCH is asserting it; a full hold
    // buffer throttles new requests until decode takes the held word.
    assign reqActive  = (state == FETCH) && !holdFull;
    assign respAccept = reqActive && ImemValidIn && !redirect;
    assign respDrop   = ImemValidIn && ((reqActive && redirect) || (state == DRAIN));

    // Next-state, next-PC and IF/ID selection. A redirect overrides stall and
    // kills both the IF/ID contents and any held word.
    always_comb begin
        nextState = state;
        nextPc    = pc;
        nextIfId  = ifId;
        holdLoad  = 1'b0;
        holdDrain = 1'b0;
        holdClear = 1'b0;

        case (state)
            BOOT:  nextState = FETCH;
            FETCH: if (redirect && reqActive && !ImemValidIn) nextState = DRAIN;
            DRAIN: if (ImemValidIn) nextState = FETCH;
            default: nextState = BOOT;
        endcase

        if (redirect) begin
            nextPc    = redirectTarget;
            holdClear = 1'b1;
            nextIfId  = BUBBLE;
        end else begin
            if (respAccept) begin
                nextPc = pcPlus4;
            end
            if (StallIn) begin
                holdLoad = respAccept;
            end else if (respAccept) begin
                nextIfId = '{instr: ImemDataIn, pc4: pcPlus4, valid: 1'b1};
            end else if (holdFull) begin
                nextIfId  = '{instr: holdInstr, pc4: holdPc4, valid: 1'b1};
                holdDrain = 1'b1;
            end else begin
                nextIfId = BUBBLE;
            end
        end
    end

    // State, PC and IF/ID register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= BOOT;
            pc    <= RESET_PC_ALIGNED;
            ifId  <= BUBBLE;
        end else begin
            state <= nextState;
            pc    <= nextPc;
            ifId  <= nextIfId;
        end
    end

    fetch_hold_buffer holdBuffer (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (holdLoad),
        .drain     (holdDrain),
        .clear     (holdClear),
        .loadInstr (ImemDataIn),
        .loadPc4   (pcPlus4),
        .full      (holdFull),
        .holdInstr (holdInstr),
        .holdPc4   (holdPc4)
    );

    assign ImemReqOut     = reqActive;
    assign ImemAddrOut    = pc;
    assign InstructionOut = ifId.instr;
    assign PCValueOut     = ifId.pc4;
    assign ValidOut       = ifId.valid;

`ifdef FETCH_STATS_EN
    // Saturating activity counters: accepted responses and squashed ones.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            FetchCountOut  <= 32'h0;
            SquashCountOut <= 32'h0;
        end else begin
            if (respAccept && (FetchCountOut != 32'hFFFF_FFFF)) begin
                FetchCountOut <= FetchCountOut + 32'd1;
            end
            if (respDrop && (SquashCountOut != 32'hFFFF_FFFF)) begin
                SquashCountOut <= SquashCountOut + 32'd1;
            end
        end
    end
`endif

endmodule
